uart_cmd_sequencer: RTL and testbench
=====================================

Name: uart_cmd_sequencer

Overview:
- Synthesizable host-side UART transaction engine. Sits between a controller (CPU/LA/test FSM) and a `uart` core's AXI-stream ports.
- Replays a loaded burst of N command bytes into the UART transmitter, then collects M response bytes from the UART receiver into a readback buffer.
- Supervises the response with an inter-byte timeout. It replaces ad-hoc per-byte send/wait sequencing toward the ALU top.

Parameters:
- DATA_WIDTH, 8, width of each UART byte/word.
- MAX_TX_WORDS, 16, depth of the command buffer (power of 2, >=2).
- MAX_RX_WORDS, 16, depth of the response buffer (power of 2, >=2).
- TIMEOUT_CYCLES, 12000, clk cycles allowed with no received word while collecting (about 4 frames at prescale 35).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en_i  in  1  write strobe into the command buffer.
- wr_addr_i  in  $clog2(MAX_TX_WORDS)  command buffer address.
- wr_data_i  in  DATA_WIDTH  command word.
- start_i  in  1  launch a transaction (single-cycle pulse).
- tx_len_i  in  $clog2(MAX_TX_WORDS)+1  command words to send.
- rx_len_i  in  $clog2(MAX_RX_WORDS)+1  response words expected.
- busy_o  out  1  transaction in progress.
- done_o  out  1  one-cycle completion pulse.
- timeout_o  out  1  sticky: last transaction timed out.
- overflow_o  out  1  sticky: unsolicited word received and dropped.
- rx_count_o  out  $clog2(MAX_RX_WORDS)+1  response words captured.
- rd_addr_i  in  $clog2(MAX_RX_WORDS)  response buffer read address.
- rd_data_o  out  DATA_WIDTH  response word, registered.
- m_axis_tdata  out  DATA_WIDTH  to uart s_axis_tdata.
- m_axis_tvalid  out  1.
- m_axis_tready  in  1.
- s_axis_tdata  in  DATA_WIDTH  from uart m_axis_tdata.
- s_axis_tvalid  in  1.
- s_axis_tready  out  1.

Behaviour:
- Reset (rst_n=0, async) sets all outputs to 0: busy, done, timeout, overflow, rx_count, rd_data, m_axis_tvalid/tdata. s_axis_tready is also 0. FSM goes to IDLE. Buffer contents are undefined.
- FSM states:
  - IDLE: on start_i, latch lengths, clear timeout_o/overflow_o/rx_count_o, assert busy_o next cycle. Go to SEND if tx_len>0, else RECV if rx_len>0, else DONE.
  - SEND: present buffer[idx] with m_axis_tvalid=1. tdata/tvalid stay stable until tready. On the transfer, idx++. After the last transfer go to RECV (rx_len>0) or DONE.
  - RECV: s_axis_tready=1. Each transfer writes rx_buf[rx_count] and increments rx_count and resets the timer. When rx_count==rx_len go to DONE. When the timer reaches TIMEOUT_CYCLES-1 with no transfer, set timeout_o and go to DONE.
  - DONE: done_o=1 for exactly one cycle, busy_o falls the same cycle, then IDLE.
- Length clamping: tx_len_i>MAX_TX_WORDS clamps to MAX_TX_WORDS; same rule for rx_len_i.
- The timer starts on entry to RECV. It covers the first-word latency as well as the inter-word gap.
- In IDLE, SEND and DONE, s_axis_tready=1. Any word accepted there is discarded and sets overflow_o. This keeps the UART core from raising rx_overrun.
- start_i while busy is ignored. wr_en_i while busy is ignored; the buffer is frozen during SEND.
- A word arriving on the same cycle timeout would fire is accepted; timeout does not assert.
- rd_data_o = rx_buf[rd_addr_i], one-cycle latency, readable at any time.
- Reset mid-transaction: immediate return to IDLE. m_axis_tvalid drops without handshake, the only permitted AXIS violation.

Decomposition:
- Package uart_seq_pkg: state enum (IDLE, SEND, RECV, DONE) and a length-width helper function.
- One sub-module, uart_seq_buf: a simple dual-port register array (sync write, registered read), instantiated twice for the command and response buffers.

Test Plan:
- Load buffer with 0x01,0x05,0x07 and start with tx_len=3, rx_len=2. The loopback model returns 0x0C,0x00. Required: the three words are sent in order, done_o pulses once, rx_count_o=2, rd_data_o reads 0x0C then 0x00, timeout_o=0.
- tx_len=2, rx_len=4, model returns only 2 words. Required: timeout_o=1 exactly TIMEOUT_CYCLES after the 2nd word, rx_count_o=2, done_o pulses.
- Hold m_axis_tready low for 50 cycles mid-burst. Required: m_axis_tdata is stable and no word is duplicated or lost.
- Inject a stray word 0xAA while IDLE. Required: overflow_o=1, rx_count_o unchanged. The next start clears overflow_o.
- tx_len=0, rx_len=0: done_o pulses 2 cycles after start, with no AXIS traffic. tx_len=31 on a 16-deep buffer: exactly 16 words are sent.
- Assert rst_n low during SEND word 2. Required: all outputs are 0 the same cycle, and a following transaction completes normally.

Source files
------------

// File: rtl/uart_seq_pkg.sv
// rtl/uart_seq_pkg.sv - shared state encoding and sizing helper for the UART command sequencer
package uart_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SEND = 2'd1;
    localparam state_t ST_RECV = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // A length field must hold 0..depth inclusive, hence one bit more than an address.
    function automatic int len_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_seq_buf.sv
// rtl/uart_seq_buf.sv - simple dual-port register array, sync write, registered read
//
// Ports:
//   clk, rst_n       clock, async active-low reset (clears the read register only)
//   wr_en/wr_addr/wr_data  synchronous write port
//   rd_addr/rd_data  read port, one-cycle latency
module uart_seq_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; contents are undefined after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// rtl/uart_cmd_sequencer.sv - replays a command burst into a UART and collects the response
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   wr_en_i/wr_addr_i/wr_data_i   command buffer load port (honoured only in IDLE)
//   start_i, tx_len_i, rx_len_i   launch pulse and burst lengths (clamped to buffer depth)
//   busy_o, done_o                transaction in progress / one-cycle completion pulse
//   timeout_o, overflow_o         sticky status, cleared by the next start
//   rx_count_o                    response words captured
//   rd_addr_i/rd_data_o           response readback, one-cycle latency
//   m_axis_*                      command words toward the UART transmitter
//   s_axis_*                      response words from the UART receiver
module uart_cmd_sequencer
    import uart_seq_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_TX_WORDS   = 16,
    parameter int MAX_RX_WORDS   = 16,
    parameter int TIMEOUT_CYCLES = 12000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en_i,
    input  logic [$clog2(MAX_TX_WORDS)-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0]           wr_data_i,
    input  logic                            start_i,
    input  logic [$clog2(MAX_TX_WORDS):0]   tx_len_i,
    input  logic [$clog2(MAX_RX_WORDS):0]   rx_len_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            timeout_o,
    output logic                            overflow_o,
    output logic [$clog2(MAX_RX_WORDS):0]   rx_count_o,
    input  logic [$clog2(MAX_RX_WORDS)-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0]           rd_data_o,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready
);

    localparam int TXA = $clog2(MAX_TX_WORDS);
    localparam int TXL = len_width(MAX_TX_WORDS);
    localparam int RXA = $clog2(MAX_RX_WORDS);
    localparam int RXL = len_width(MAX_RX_WORDS);
    localparam int TW  = $clog2(TIMEOUT_CYCLES);

    state_t          state_q;
    logic            busy_q;
    logic            done_q;
    logic            timeout_q;
    logic            overflow_q;
    logic            tvalid_q;
    logic            ready_q;
    logic [TXL-1:0]  tx_len_q;
    logic [RXL-1:0]  rx_len_q;
    logic [TXL-1:0]  tx_idx_q;
    logic [TXL-1:0]  tx_idx_d;
    logic [RXL-1:0]  rx_count_q;
    logic [TW-1:0]   timer_q;
    logic [TXL-1:0]  tx_len_c;
    logic [RXL-1:0]  rx_len_c;
    logic [DATA_WIDTH-1:0] tx_word;
    logic            tx_fire;
    logic            rx_fire;

    assign tx_len_c = (tx_len_i > TXL'(MAX_TX_WORDS)) ? TXL'(MAX_TX_WORDS) : tx_len_i;
    assign rx_len_c = (rx_len_i > RXL'(MAX_RX_WORDS)) ? RXL'(MAX_RX_WORDS) : rx_len_i;

    assign tx_fire = tvalid_q & m_axis_tready;
    // The receiver is always drained once out of reset so the UART never overruns;
    // only words landing in RECV are kept.
    assign rx_fire = ready_q & s_axis_tvalid;

    // The command buffer read is registered, so it is addressed with the next index;
    // its output then always lines up with tx_idx_q and holds steady during a stall.
    always_comb begin
        tx_idx_d = tx_idx_q;
        if (state_q == ST_IDLE) begin
            tx_idx_d = '0;
        end else if (state_q == ST_SEND && tx_fire) begin
            tx_idx_d = tx_idx_q + 1'b1;
        end
    end

    uart_seq_buf #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (MAX_TX_WORDS)
    ) u_tx_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en_i && state_q == ST_IDLE),
        .wr_addr (wr_addr_i),
        .wr_data (wr_data_i),
        .rd_addr (tx_idx_d[TXA-1:0]),
        .rd_data (tx_word)
    );

    uart_seq_buf #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (MAX_RX_WORDS)
    ) u_rx_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (rx_fire && state_q == ST_RECV),
        .wr_addr (rx_count_q[RXA-1:0]),
        .wr_data (s_axis_tdata),
        .rd_addr (rd_addr_i),
        .rd_data (rd_data_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
            tvalid_q   <= 1'b0;
            ready_q    <= 1'b0;
            tx_len_q   <= '0;
            rx_len_q   <= '0;
            tx_idx_q   <= '0;
            rx_count_q <= '0;
            timer_q    <= '0;
        end else begin
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            tx_idx_q <= tx_idx_d;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        tx_len_q   <= tx_len_c;
                        rx_len_q   <= rx_len_c;
                        timeout_q  <= 1'b0;
                        overflow_q <= 1'b0;
                        rx_count_q <= '0;
                        timer_q    <= '0;
                        busy_q     <= 1'b1;
                        if (tx_len_c != '0) begin
                            state_q  <= ST_SEND;
                            tvalid_q <= 1'b1;
                        end else if (rx_len_c != '0) begin
                            state_q <= ST_RECV;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_SEND: begin
                    if (tx_fire && (tx_idx_q + 1'b1 == tx_len_q)) begin
                        tvalid_q <= 1'b0;
                        timer_q  <= '0;
                        state_q  <= (rx_len_q != '0) ? ST_RECV : ST_DONE;
                    end
                end
                ST_RECV: begin
                    // A word on the expiry cycle wins over the timeout.
                    if (rx_fire) begin
                        rx_count_q <= rx_count_q + 1'b1;
                        timer_q    <= '0;
                        if (rx_count_q + 1'b1 == rx_len_q) begin
                            state_q <= ST_DONE;
                        end
                    end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
            if (rx_fire && state_q != ST_RECV) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign timeout_o     = timeout_q;
    assign overflow_o    = overflow_q;
    assign rx_count_o    = rx_count_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tvalid_q ? tx_word : '0;
    assign s_axis_tready = ready_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb/tb_uart_cmd_sequencer.sv - scoreboard bench for uart_cmd_sequencer
module tb_uart_cmd_sequencer;

    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en_i;
    logic [3:0] wr_addr_i;
    logic [7:0] wr_data_i;
    logic       start_i;
    logic [4:0] tx_len_i;
    logic [4:0] rx_len_i;
    logic       busy_o;
    logic       done_o;
    logic       timeout_o;
    logic       overflow_o;
    logic [4:0] rx_count_o;
    logic [3:0] rd_addr_i;
    logic [7:0] rd_data_o;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;

    uart_cmd_sequencer #(
        .DATA_WIDTH     (8),
        .MAX_TX_WORDS   (16),
        .MAX_RX_WORDS   (16),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en_i       (wr_en_i),
        .wr_addr_i     (wr_addr_i),
        .wr_data_i     (wr_data_i),
        .start_i       (start_i),
        .tx_len_i      (tx_len_i),
        .rx_len_i      (rx_len_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .timeout_o     (timeout_o),
        .overflow_o    (overflow_o),
        .rx_count_o    (rx_count_o),
        .rd_addr_i     (rd_addr_i),
        .rd_data_o     (rd_data_o),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int sent_cnt = 0;
    int done_cnt = 0;
    int stall_after = -1;
    int stall_len   = 0;

    logic [7:0] tx_exp_q[$];
    logic [7:0] rd_exp_q[$];
    logic [7:0] held_data;
    logic       held_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference for the loopback ALU: opcode 1 adds, anything else xors; 16-bit result.
    function automatic logic [15:0] alu_model(input logic [7:0] op, input logic [7:0] a,
                                              input logic [7:0] b);
        if (op == 8'h01) return 16'(a) + 16'(b);
        return 16'(a ^ b);
    endfunction

    // Transmit-side monitor: ordering, no extra words, stability while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_valid = 1'b0;
        end else if (m_axis_tvalid && m_axis_tready) begin
            if (tx_exp_q.size() == 0) begin
                check("tx_extra", 32'd1, 32'd0);
            end else begin
                check("tx_word", m_axis_tdata, tx_exp_q.pop_front());
            end
            sent_cnt++;
            held_valid = 1'b0;
        end else if (m_axis_tvalid) begin
            if (held_valid) check("tx_stable", m_axis_tdata, held_data);
            held_data  = m_axis_tdata;
            held_valid = 1'b1;
        end else begin
            held_valid = 1'b0;
        end
        if (rst_n && done_o) done_cnt++;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_len > 0 && sent_cnt == stall_after) begin
                m_axis_tready = 1'b0;
                stall_len--;
            end else begin
                m_axis_tready = 1'b1;
            end
        end
    end

    task automatic wr(input int addr, input logic [7:0] data);
        wr_en_i   = 1'b1;
        wr_addr_i = 4'(addr);
        wr_data_i = data;
        @(posedge clk);
        #1;
        wr_en_i = 1'b0;
    endtask

    task automatic start_txn(input int tx, input int rx);
        start_i  = 1'b1;
        tx_len_i = 5'(tx);
        rx_len_i = 5'(rx);
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_sent(input int target);
        int n = 0;
        while (sent_cnt < target && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sent_cnt < target) check("wait_sent_timeout", 32'(sent_cnt), 32'(target));
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done_o && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_seen", 32'(done_o), 32'd1);
    endtask

    // Returns #1 after the edge on which the word was accepted.
    task automatic send_word(input logic [7:0] data);
        logic ok = 1'b0;
        int   n  = 0;
        s_axis_tdata  = data;
        s_axis_tvalid = 1'b1;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = s_axis_tready;
            @(posedge clk);
            #1;
            n++;
        end
        s_axis_tvalid = 1'b0;
        if (!ok) check("send_word_timeout", 32'd0, 32'd1);
    endtask

    task automatic read_back(input int n);
        for (int i = 0; i < n; i++) begin
            rd_addr_i = 4'(i);
            @(posedge clk);
            #1;
            if (rd_exp_q.size() != 0) check("rd_data", rd_data_o, rd_exp_q.pop_front());
        end
    endtask

    task automatic run_basic();
        logic [15:0] r;
        int d0;
        wr(0, 8'h01);
        wr(1, 8'h05);
        wr(2, 8'h07);
        tx_exp_q.push_back(8'h01);
        tx_exp_q.push_back(8'h05);
        tx_exp_q.push_back(8'h07);
        d0 = done_cnt;
        start_txn(3, 2);
        wait_sent(sent_cnt + 3 - (3 - tx_exp_q.size()));
        r = alu_model(8'h01, 8'h05, 8'h07);
        rd_exp_q.push_back(r[7:0]);
        rd_exp_q.push_back(r[15:8]);
        send_word(r[7:0]);
        send_word(r[15:8]);
        wait_done();
        repeat (3) @(posedge clk);
        #1;
        check("basic_done_once", 32'(done_cnt - d0), 32'd1);
        check("basic_rx_count", 32'(rx_count_o), 32'd2);
        check("basic_timeout", 32'(timeout_o), 32'd0);
        check("basic_tx_drained", 32'(tx_exp_q.size()), 32'd0);
        read_back(2);
    endtask

    initial begin
        int base;
        int cyc;
        int d0;
        rst_n = 1'b0;
        wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
        start_i = 1'b0; tx_len_i = '0; rx_len_i = '0;
        rd_addr_i = '0; s_axis_tdata = '0; s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        #12;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_flags", {30'd0, timeout_o, overflow_o}, 32'd0);
        check("rst_rx_count", 32'(rx_count_o), 32'd0);
        check("rst_rd_data", 32'(rd_data_o), 32'd0);
        check("rst_m_axis", {23'd0, m_axis_tvalid, m_axis_tdata}, 32'd0);
        check("rst_s_tready", 32'(s_axis_tready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic burst with loopback response.
        run_basic();

        // Short response: timeout measured from the last accepted word.
        wr(0, 8'h02);
        wr(1, 8'h09);
        tx_exp_q.push_back(8'h02);
        tx_exp_q.push_back(8'h09);
        start_txn(2, 4);
        wait_sent(sent_cnt + 2);
        rd_exp_q.push_back(8'h11);
        rd_exp_q.push_back(8'h22);
        send_word(8'h11);
        send_word(8'h22);
        cyc = 0;
        while (!timeout_o && cyc < 4 * TO) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("timeout_cycles", 32'(cyc), 32'(TO));
        wait_done();
        check("to_rx_count", 32'(rx_count_o), 32'd2);
        check("to_flag", 32'(timeout_o), 32'd1);
        read_back(2);

        // 50-cycle back-pressure after the second word of a 4-word burst.
        for (int i = 0; i < 4; i++) begin
            wr(i, 8'(8'h31 + i));
            tx_exp_q.push_back(8'(8'h31 + i));
        end
        base = sent_cnt;
        stall_after = base + 2;
        stall_len   = 50;
        start_txn(4, 0);
        wait_sent(base + 4);
        wait_done();
        check("stall_sent", 32'(sent_cnt - base), 32'd4);
        check("stall_drained", 32'(tx_exp_q.size()), 32'd0);
        check("stall_timeout", 32'(timeout_o), 32'd0);

        // Stray word while idle.
        repeat (2) @(posedge clk);
        #1;
        d0 = int'(rx_count_o);
        send_word(8'hAA);
        @(posedge clk);
        #1;
        check("stray_overflow", 32'(overflow_o), 32'd1);
        check("stray_rx_count", 32'(rx_count_o), 32'(d0));

        // Empty transaction: done two cycles after start, no AXIS traffic.
        base = sent_cnt;
        start_txn(0, 0);
        check("empty_busy", 32'(busy_o), 32'd1);
        check("empty_overflow_cleared", 32'(overflow_o), 32'd0);
        check("empty_done_early", 32'(done_o), 32'd0);
        @(posedge clk);
        #1;
        check("empty_done", 32'(done_o), 32'd1);
        check("empty_busy_fall", 32'(busy_o), 32'd0);
        check("empty_no_traffic", 32'(sent_cnt - base), 32'd0);

        // Over-long tx length is clamped to the buffer depth.
        for (int i = 0; i < 16; i++) begin
            wr(i, 8'(i * 3 + 1));
            tx_exp_q.push_back(8'(i * 3 + 1));
        end
        base = sent_cnt;
        start_txn(31, 0);
        wait_sent(base + 16);
        wait_done();
        repeat (4) @(posedge clk);
        #1;
        check("clamp_sent", 32'(sent_cnt - base), 32'd16);
        check("clamp_drained", 32'(tx_exp_q.size()), 32'd0);

        // Reset while word 2 is being presented.
        for (int i = 0; i < 3; i++) begin
            wr(i, 8'(8'h50 + i));
            tx_exp_q.push_back(8'(8'h50 + i));
        end
        base = sent_cnt;
        stall_after = base + 1;
        stall_len   = 20;
        start_txn(3, 1);
        wait_sent(base + 1);
        repeat (3) @(posedge clk);
        check("mid_presenting", 32'(m_axis_tvalid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_m_axis", {23'd0, m_axis_tvalid, m_axis_tdata}, 32'd0);
        check("mid_rst_s_tready", 32'(s_axis_tready), 32'd0);
        check("mid_rst_misc", {16'd0, done_o, timeout_o, overflow_o, rx_count_o, rd_data_o}, 32'd0);
        stall_len = 0;
        tx_exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_basic();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
